imem_arbiter: RTL and testbench

Two-port arbiter that shares the single port of the 64 KB instruction memory at 0x00010000 between the CPU bus and the crypto accelerator's firmware-read master. Its job is to serialise their accesses with round-robin fairness and to block CPU writes to instruction memory while a firmware hash is in progress, so hashed code cannot be altered mid-measurement. It sits between the SoC address decode, the crypto accelerator's memory master port, and the instruction memory.

---
 rtl/imem_arbiter_if.sv | 53 +++++
 rtl/imem_arbiter.sv | 108 ++++++++++
 tb/tb_imem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bundle of the CPU, crypto-DMA and instruction-memory signals around imem_arbiter.
// The arbiter takes the slave modport; the surrounding SoC (or bench) takes master.
interface imem_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  cpu_valid;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [3:0]            cpu_wstrb;
  logic                  cpu_ready;
  logic [31:0]           cpu_rdata;

  logic                  dma_valid;
  logic [31:0]           dma_addr;
  logic                  dma_ready;
  logic [31:0]           dma_rdata;

  logic                  hash_busy;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_rdata;

  logic                  addr_err;
  logic                  wr_blocked;
  logic [7:0]            blocked_count;
  logic [1:0]            fsm_state;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    input  dma_valid, dma_addr,
    output dma_ready, dma_rdata,
    input  hash_busy,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata,
    output addr_err, wr_blocked, blocked_count, fsm_state
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    output dma_valid, dma_addr,
    input  dma_ready, dma_rdata,
    output hash_busy,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata,
    input  addr_err, wr_blocked, blocked_count, fsm_state
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the instruction-memory port between CPU and crypto DMA,
// suppressing CPU writes while a firmware hash is running.
module imem_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          ADDR_WIDTH = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_arbiter_if.slave   bus
);
  // Handshake: a requester raises valid and holds it (with stable address/data)
  // until its ready pulse; ready is high for exactly one cycle, one cycle after issue.

  localparam logic [31:0] WIN_BYTES = 32'd4 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP_CPU = 2'd1,
    RESP_DMA = 2'd2
  } state_t;

  state_t      state;
  logic        last_dma;
  logic        rd_ok;
  logic        cpu_ready_q;
  logic        dma_ready_q;
  logic        addr_err_q;
  logic        wr_blocked_q;
  logic [7:0]  count_q;

  logic        issue;
  logic        grant_cpu;
  logic        grant_dma;
  logic [31:0] sel_addr;
  logic [31:0] offset;
  logic        in_win;
  logic        is_write;
  logic        blocked;
  logic        access;

  // Issue is also gated by rst_n so the memory port stays quiet during reset.
  always_comb begin
    issue     = (state == IDLE) && rst_n;
    grant_cpu = issue && bus.cpu_valid && (!bus.dma_valid || last_dma);
    grant_dma = issue && bus.dma_valid && !grant_cpu;
    sel_addr  = grant_cpu ? bus.cpu_addr : bus.dma_addr;
    offset    = sel_addr - BASE_ADDR;
    in_win    = offset < WIN_BYTES;
    is_write  = grant_cpu && (bus.cpu_wstrb != 4'd0);
    blocked   = is_write && bus.hash_busy && in_win;
    access    = (grant_cpu || grant_dma) && in_win && !blocked;
  end

  assign bus.mem_en    = access;
  assign bus.mem_we    = access && is_write;
  assign bus.mem_addr  = access ? offset[ADDR_WIDTH+1:2] : '0;
  assign bus.mem_wdata = (access && grant_cpu) ? bus.cpu_wdata : 32'd0;
  assign bus.mem_wstrb = (access && grant_cpu) ? bus.cpu_wstrb : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_dma     <= 1'b1;
      rd_ok        <= 1'b0;
      cpu_ready_q  <= 1'b0;
      dma_ready_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      wr_blocked_q <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state    <= RESP_CPU;
            last_dma <= 1'b0;
          end else if (grant_dma) begin
            state    <= RESP_DMA;
            last_dma <= 1'b1;
          end
          cpu_ready_q  <= grant_cpu;
          dma_ready_q  <= grant_dma;
          addr_err_q   <= (grant_cpu || grant_dma) && !in_win;
          wr_blocked_q <= blocked;
          rd_ok        <= access && !is_write;
        end
        default: begin
          // RESP_CPU / RESP_DMA: the pulses above are live this cycle only.
          if (wr_blocked_q && (count_q != 8'hFF)) count_q <= count_q + 8'd1;
          state        <= IDLE;
          cpu_ready_q  <= 1'b0;
          dma_ready_q  <= 1'b0;
          addr_err_q   <= 1'b0;
          wr_blocked_q <= 1'b0;
          rd_ok        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_ready     = cpu_ready_q;
  assign bus.dma_ready     = dma_ready_q;
  assign bus.cpu_rdata     = (cpu_ready_q && rd_ok) ? bus.mem_rdata : 32'd0;
  assign bus.dma_rdata     = (dma_ready_q && rd_ok) ? bus.mem_rdata : 32'd0;
  assign bus.addr_err      = addr_err_q;
  assign bus.wr_blocked    = wr_blocked_q;
  assign bus.blocked_count = count_q;
  assign bus.fsm_state     = state;
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a byte-strobed instruction-memory model.
module tb_imem_arbiter;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;

  imem_arbiter_if #(.ADDR_WIDTH(14)) bus ();

  imem_arbiter #(
    .BASE_ADDR  (32'h0001_0000),
    .ADDR_WIDTH (14)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: read data one cycle after mem_en
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one CPU access from IDLE, checks issue cycle and response cycle
  task automatic cpu_access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic hb, input logic exp_en,
                            input logic [13:0] exp_maddr, input logic [31:0] exp_rdata,
                            input logic exp_err, input logic exp_blk);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_wstrb = wstrb;
    bus.hash_busy = hb;
    @(negedge clk);
    chk({tag, ".mem_en"},   bus.mem_en, exp_en);
    chk({tag, ".mem_we"},   bus.mem_we, exp_en && (wstrb != 4'd0));
    chk({tag, ".mem_addr"}, bus.mem_addr, exp_maddr);
    step();
    @(negedge clk);
    chk({tag, ".cpu_ready"},  bus.cpu_ready, 1'b1);
    chk({tag, ".cpu_rdata"},  bus.cpu_rdata, exp_rdata);
    chk({tag, ".addr_err"},   bus.addr_err, exp_err);
    chk({tag, ".wr_blocked"}, bus.wr_blocked, exp_blk);
    step();
    bus.cpu_valid = 1'b0;
    bus.hash_busy = 1'b0;
  endtask

  task automatic dma_access(input string tag, input logic [31:0] addr, input logic hb,
                            input logic exp_en, input logic [13:0] exp_maddr,
                            input logic [31:0] exp_rdata, input logic exp_err);
    bus.dma_valid = 1'b1;
    bus.dma_addr  = addr;
    bus.hash_busy = hb;
    @(negedge clk);
    chk({tag, ".mem_en"},    bus.mem_en, exp_en);
    chk({tag, ".mem_we"},    bus.mem_we, 1'b0);
    chk({tag, ".mem_wstrb"}, bus.mem_wstrb, 4'd0);
    chk({tag, ".mem_addr"},  bus.mem_addr, exp_maddr);
    step();
    @(negedge clk);
    chk({tag, ".dma_ready"}, bus.dma_ready, 1'b1);
    chk({tag, ".cpu_ready"}, bus.cpu_ready, 1'b0);
    chk({tag, ".dma_rdata"}, bus.dma_rdata, exp_rdata);
    chk({tag, ".addr_err"},  bus.addr_err, exp_err);
    step();
    bus.dma_valid = 1'b0;
    bus.hash_busy = 1'b0;
  endtask

  logic [7:0]  exp_cpu_rdy;
  logic [7:0]  exp_dma_rdy;
  logic [13:0] exp_cont_addr [8];

  initial begin
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    mem[0]        = 32'hA5A5_0000;
    mem[14'h3FFF] = 32'h0BAD_F00D;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = 32'd0;
    bus.cpu_wdata = 32'd0;
    bus.cpu_wstrb = 4'd0;
    bus.dma_valid = 1'b0;
    bus.dma_addr  = 32'd0;
    bus.hash_busy = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.cpu_ready", bus.cpu_ready, 1'b0);
    chk("rst.dma_ready", bus.dma_ready, 1'b0);
    chk("rst.mem_en",    bus.mem_en, 1'b0);
    chk("rst.count",     bus.blocked_count, 8'd0);
    chk("rst.state",     bus.fsm_state, 2'd0);
    chk("rst.addr_err",  bus.addr_err, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // reset asserted while the CPU read is in its response cycle
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'h0001_0000;
    @(negedge clk);
    chk("midrst.issue_en", bus.mem_en, 1'b1);
    step();
    @(negedge clk);
    chk("midrst.state_resp", bus.fsm_state, 2'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.cpu_ready", bus.cpu_ready, 1'b0);
    chk("midrst.cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("midrst.mem_en",    bus.mem_en, 1'b0);
    chk("midrst.state",     bus.fsm_state, 2'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.reissue_en",   bus.mem_en, 1'b1);
    chk("midrst.reissue_addr", bus.mem_addr, 14'h0000);
    step();
    @(negedge clk);
    chk("midrst.ready",  bus.cpu_ready, 1'b1);
    chk("midrst.rdata",  bus.cpu_rdata, 32'hA5A5_0000);
    step();
    bus.cpu_valid = 1'b0;

    cpu_access("wr_beef", 32'h0001_0040, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 14'h010, 32'd0, 1'b0, 1'b0);
    cpu_access("rd_beef", 32'h0001_0040, 32'd0, 4'h0, 1'b0, 1'b1, 14'h010, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cpu_access("wr_byte", 32'h0001_0043, 32'h0000_00CC, 4'h1, 1'b0, 1'b1, 14'h010, 32'd0, 1'b0, 1'b0);
    cpu_access("rd_byte", 32'h0001_0040, 32'd0, 4'h0, 1'b0, 1'b1, 14'h010, 32'hDEAD_BECC, 1'b0, 1'b0);
    cpu_access("rd_top",  32'h0001_FFFC, 32'd0, 4'h0, 1'b0, 1'b1, 14'h3FFF, 32'h0BAD_F00D, 1'b0, 1'b0);
    cpu_access("rd_below", 32'h0000_FFFC, 32'd0, 4'h0, 1'b0, 1'b0, 14'h0, 32'd0, 1'b1, 1'b0);

    // hash lock
    cpu_access("wr_locked", 32'h0001_0000, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 14'h0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("lock.count", bus.blocked_count, 8'd1);
    step();
    cpu_access("rd_after_lock", 32'h0001_0000, 32'd0, 4'h0, 1'b0, 1'b1, 14'h0, 32'hA5A5_0000, 1'b0, 1'b0);

    dma_access("dma_oow", 32'h0002_0000, 1'b0, 1'b0, 14'h0, 32'd0, 1'b1);
    bus.cpu_wstrb = 4'hF;
    dma_access("dma_rd", 32'h0001_0040, 1'b1, 1'b1, 14'h010, 32'hDEAD_BECC, 1'b0);

    // contention: last grant was DMA, so CPU goes first
    exp_cpu_rdy = 8'b0010_0010;
    exp_dma_rdy = 8'b1000_1000;
    exp_cont_addr = '{14'h010, 14'h0, 14'h3FFF, 14'h0, 14'h010, 14'h0, 14'h3FFF, 14'h0};
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'h0001_0040;
    bus.cpu_wstrb = 4'h0;
    bus.dma_valid = 1'b1;
    bus.dma_addr  = 32'h0001_FFFC;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("cont%0d.cpu_ready", i), bus.cpu_ready, exp_cpu_rdy[i]);
      chk($sformatf("cont%0d.dma_ready", i), bus.dma_ready, exp_dma_rdy[i]);
      chk($sformatf("cont%0d.mem_addr", i),  bus.mem_addr, exp_cont_addr[i]);
      step();
    end
    bus.cpu_valid = 1'b0;
    bus.dma_valid = 1'b0;

    // saturation: 260 more blocked writes on top of the one above
    for (int i = 0; i < 260; i++)
      cpu_access($sformatf("sat%0d", i), 32'h0001_0000, 32'h1234_5678, 4'hF, 1'b1,
                 1'b0, 14'h0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("sat.count", bus.blocked_count, 8'd255);
    step();
    cpu_access("rd_final", 32'h0001_0000, 32'd0, 4'h0, 1'b0, 1'b1, 14'h0, 32'hA5A5_0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
